// File: rtl/monitor_pkg.sv
// Shared definitions for the gate pattern monitor: FSM state encoding and
// the default counter width.
package monitor_pkg;

  localparam int CNT_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } mon_state_t;

endpackage

// File: rtl/edge_detect.sv
// Registers an N-bit vector once and flags rising/falling edges by comparing
// the registered value against the previous registered value.
module edge_detect #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [N-1:0] d,
  output logic [N-1:0] cur,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] cur_q, cur_d;
  logic [N-1:0] prev_q, prev_d;

  // Next-state: sample input, shift current into history.
  always_comb begin
    cur_d  = d;
    prev_d = cur_q;
  end

  // History registers hold while disabled so edges straddling a CE-low gap still show.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q  <= {N{1'b0}};
      prev_q <= {N{1'b0}};
    end else if (ce) begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign cur  = cur_q;
  assign rise = cur_q & ~prev_q;
  assign fall = ~cur_q & prev_q;

endmodule

// File: rtl/gate_pattern_monitor.sv
// Measures period, on-time, dead-time and secondary phase of a gate-drive
// pattern, with stall detection and sticky shoot-through flags.
module gate_pattern_monitor
  import monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic [3:0]       Sp,
  input  logic [3:0]       Ss,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] t_on,
  output logic [CNT_W-1:0] dead,
  output logic [CNT_W-1:0] phase,
  output logic             phase_ok,
  output logic             meas_valid,
  output logic             stall,
  output logic [1:0]       fault
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) sat_inc = CNT_MAX;
    else              sat_inc = v + CNT_ONE;
  endfunction

  logic [7:0] in_cur_s, in_rise_s, in_fall_s;
  logic       edges_unused_s;

  edge_detect #(.N(8)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .ce   (CE),
    .d    ({Ss, Sp}),
    .cur  (in_cur_s),
    .rise (in_rise_s),
    .fall (in_fall_s)
  );

  logic [3:0] sp_cur_s, ss_cur_s;
  logic       sp0_rise_s, sp0_fall_s, sp1_rise_s, ss0_rise_s;

  assign sp_cur_s       = in_cur_s[3:0];
  assign ss_cur_s       = in_cur_s[7:4];
  assign sp0_rise_s     = in_rise_s[0];
  assign sp1_rise_s     = in_rise_s[1];
  assign ss0_rise_s     = in_rise_s[4];
  assign sp0_fall_s     = in_fall_s[0];
  assign edges_unused_s = ^{in_rise_s[7:5], in_rise_s[3:2], in_fall_s[7:1]};

  mon_state_t       state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, ton_cnt_q, ton_cnt_d;
  logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d, ph_cnt_q, ph_cnt_d;
  logic             dead_run_q, dead_run_d, dead_done_q, dead_done_d;
  logic             ph_run_q, ph_run_d, ph_done_q, ph_done_d;
  logic [CNT_W-1:0] period_q, period_d, t_on_q, t_on_d;
  logic [CNT_W-1:0] dead_q, dead_d, phase_q, phase_d;
  logic             phase_ok_q, phase_ok_d, meas_valid_q, meas_valid_d;
  logic             stall_q, stall_d;
  logic [1:0]       fault_q, fault_d;
  logic             restart_s, advance_s;
  logic [CNT_W-1:0] per_inc_s;

  // FSM next state, measurement latching, counters and fault flags.
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    ton_cnt_d    = ton_cnt_q;
    dead_cnt_d   = dead_cnt_q;
    dead_run_d   = dead_run_q;
    dead_done_d  = dead_done_q;
    ph_cnt_d     = ph_cnt_q;
    ph_run_d     = ph_run_q;
    ph_done_d    = ph_done_q;
    period_d     = period_q;
    t_on_d       = t_on_q;
    dead_d       = dead_q;
    phase_d      = phase_q;
    phase_ok_d   = phase_ok_q;
    meas_valid_d = 1'b0;
    stall_d      = stall_q;
    restart_s    = 1'b0;
    advance_s    = 1'b0;
    per_inc_s    = sat_inc(per_cnt_q);

    // A live violation beats a simultaneous clear.
    fault_d[0] = ((sp_cur_s[0] & sp_cur_s[1]) | (sp_cur_s[2] & sp_cur_s[3])) |
                 (fault_q[0] & ~fault_clr);
    fault_d[1] = ((ss_cur_s[0] & ss_cur_s[1]) | (ss_cur_s[2] & ss_cur_s[3])) |
                 (fault_q[1] & ~fault_clr);

    case (state_q)
      ST_IDLE: begin
        if (sp0_rise_s) begin
          state_d   = ST_RUN;
          restart_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (sp0_rise_s) begin
          period_d     = per_cnt_q;
          t_on_d       = ton_cnt_q;
          dead_d       = dead_done_q ? dead_cnt_q : CNT_ZERO;
          phase_d      = ph_done_q ? ph_cnt_q : CNT_ZERO;
          phase_ok_d   = ph_done_q;
          meas_valid_d = 1'b1;
          restart_s    = 1'b1;
        end else begin
          advance_s = 1'b1;
          if (per_inc_s == CNT_MAX) begin
            state_d = ST_STALL;
            stall_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_STALL: begin
        if (sp0_rise_s) begin
          state_d   = ST_RUN;
          stall_d   = 1'b0;
          restart_s = 1'b1;
        end else begin
          state_d = ST_STALL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
      end
    endcase

    if (restart_s) begin
      per_cnt_d   = CNT_ONE;
      ton_cnt_d   = CNT_ONE;
      dead_cnt_d  = CNT_ZERO;
      dead_run_d  = 1'b0;
      dead_done_d = 1'b0;
      // Secondary rising together with the primary counts as zero phase.
      ph_cnt_d    = ss0_rise_s ? CNT_ZERO : CNT_ONE;
      ph_run_d    = ~ss0_rise_s;
      ph_done_d   = ss0_rise_s;
    end else if (advance_s) begin
      per_cnt_d = per_inc_s;
      ton_cnt_d = sp_cur_s[0] ? sat_inc(ton_cnt_q) : ton_cnt_q;
      if (dead_run_q) begin
        if (sp1_rise_s) begin
          dead_run_d  = 1'b0;
          dead_done_d = 1'b1;
        end else begin
          dead_cnt_d = sat_inc(dead_cnt_q);
        end
      end else if (sp0_fall_s && !dead_done_q) begin
        dead_cnt_d = CNT_ONE;
        dead_run_d = 1'b1;
      end else begin
        dead_cnt_d = dead_cnt_q;
      end
      if (ph_run_q) begin
        if (ss0_rise_s) begin
          ph_run_d  = 1'b0;
          ph_done_d = 1'b1;
        end else begin
          ph_cnt_d = sat_inc(ph_cnt_q);
        end
      end else begin
        ph_cnt_d = ph_cnt_q;
      end
    end else begin
      per_cnt_d = per_cnt_q;
    end
  end

  // State and measurement registers; everything freezes while CE is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      per_cnt_q    <= CNT_ZERO;
      ton_cnt_q    <= CNT_ZERO;
      dead_cnt_q   <= CNT_ZERO;
      dead_run_q   <= 1'b0;
      dead_done_q  <= 1'b0;
      ph_cnt_q     <= CNT_ZERO;
      ph_run_q     <= 1'b0;
      ph_done_q    <= 1'b0;
      period_q     <= CNT_ZERO;
      t_on_q       <= CNT_ZERO;
      dead_q       <= CNT_ZERO;
      phase_q      <= CNT_ZERO;
      phase_ok_q   <= 1'b0;
      meas_valid_q <= 1'b0;
      stall_q      <= 1'b0;
      fault_q      <= 2'b00;
    end else if (CE) begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      ton_cnt_q    <= ton_cnt_d;
      dead_cnt_q   <= dead_cnt_d;
      dead_run_q   <= dead_run_d;
      dead_done_q  <= dead_done_d;
      ph_cnt_q     <= ph_cnt_d;
      ph_run_q     <= ph_run_d;
      ph_done_q    <= ph_done_d;
      period_q     <= period_d;
      t_on_q       <= t_on_d;
      dead_q       <= dead_d;
      phase_q      <= phase_d;
      phase_ok_q   <= phase_ok_d;
      meas_valid_q <= meas_valid_d;
      stall_q      <= stall_d;
      fault_q      <= fault_d;
    end
  end

  assign period     = period_q;
  assign t_on       = t_on_q;
  assign dead       = dead_q;
  assign phase      = phase_q;
  assign phase_ok   = phase_ok_q;
  assign meas_valid = meas_valid_q;
  assign stall      = stall_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_gate_pattern_monitor.sv
// Directed bench for gate_pattern_monitor: a 20-bit instance for measurement,
// fault and reset scenarios, and an 8-bit instance sharing the inputs for stall.
module tb_gate_pattern_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b1;
  logic        fault_clr = 1'b0;
  logic [3:0]  sp = 4'b0000;
  logic [3:0]  ss = 4'b0000;

  logic [19:0] period, t_on, dead, phase;
  logic        phase_ok, meas_valid, stall;
  logic [1:0]  fault;
  logic [7:0]  period8, t_on8, dead8, phase8;
  logic        phase_ok8, meas_valid8, stall8;
  logic [1:0]  fault8;

  int cmp_n = 0;
  int err_n = 0;
  int mv_cnt = 0;
  int mv8_cnt = 0;
  logic [19:0] cap_period = 20'd0, cap_t_on = 20'd0, cap_dead = 20'd0, cap_phase = 20'd0;
  logic        cap_ok = 1'b0;
  logic [7:0]  cap8_period = 8'd0;

  gate_pattern_monitor dut (
    .clk(clk), .rst(rst), .CE(ce), .Sp(sp), .Ss(ss), .fault_clr(fault_clr),
    .period(period), .t_on(t_on), .dead(dead), .phase(phase), .phase_ok(phase_ok),
    .meas_valid(meas_valid), .stall(stall), .fault(fault)
  );

  gate_pattern_monitor #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .CE(ce), .Sp(sp), .Ss(ss), .fault_clr(fault_clr),
    .period(period8), .t_on(t_on8), .dead(dead8), .phase(phase8), .phase_ok(phase_ok8),
    .meas_valid(meas_valid8), .stall(stall8), .fault(fault8)
  );

  always #5 clk = ~clk;

  // Capture every measurement pulse mid-cycle.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      mv_cnt = mv_cnt + 1;
      cap_period = period; cap_t_on = t_on; cap_dead = dead; cap_phase = phase; cap_ok = phase_ok;
    end
    if (meas_valid8 === 1'b1) begin
      mv8_cnt = mv8_cnt + 1;
      cap8_period = period8;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One period of the drive pattern; Sp[0] rises at c=0.
  task automatic run_period(input int per, input int hi, input int gap, input int ss_dly,
                            input bit sp1_en, input int ce_s, input int ce_len, input bit chk);
    for (int c = 0; c < per; c++) begin
      sp[0] = (c < hi);
      sp[1] = sp1_en && (c >= hi + gap) && (c < per - gap);
      ss[0] = (ss_dly >= 0) && (c >= ss_dly) && (c < ss_dly + 100);
      ce    = !((c >= ce_s) && (c < ce_s + ce_len));
      step(1);
      if (chk && c == 0) begin
        cmp_n++; if (meas_valid !== 1'b0) begin err_n++; $display("FAIL lat_early: got %0b exp 0", meas_valid); end
      end
      if (chk && c == 1) begin
        cmp_n++; if (meas_valid !== 1'b1) begin err_n++; $display("FAIL lat_pulse: got %0b exp 1", meas_valid); end
        cmp_n++; if (period !== 20'd1000) begin err_n++; $display("FAIL lat_period: got %0d exp 1000", period); end
      end
      if (chk && c == 2) begin
        cmp_n++; if (meas_valid !== 1'b0) begin err_n++; $display("FAIL lat_oneshot: got %0b exp 0", meas_valid); end
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(3);
    cmp_n++; if (period !== 20'd0) begin err_n++; $display("FAIL rst_period: got %0d exp 0", period); end
    cmp_n++; if (t_on !== 20'd0) begin err_n++; $display("FAIL rst_t_on: got %0d exp 0", t_on); end
    cmp_n++; if (dead !== 20'd0) begin err_n++; $display("FAIL rst_dead: got %0d exp 0", dead); end
    cmp_n++; if (phase !== 20'd0) begin err_n++; $display("FAIL rst_phase: got %0d exp 0", phase); end
    cmp_n++; if ({phase_ok, meas_valid, stall} !== 3'b000) begin err_n++; $display("FAIL rst_flags: got %b exp 000", {phase_ok, meas_valid, stall}); end
    cmp_n++; if (fault !== 2'b00) begin err_n++; $display("FAIL rst_fault: got %b exp 00", fault); end
    cmp_n++; if (stall8 !== 1'b0) begin err_n++; $display("FAIL rst_stall8: got %0b exp 0", stall8); end
    rst = 1'b1;
    step(2);
  endtask

  task automatic test_basic;
    repeat (3) run_period(1000, 490, 10, 250, 1'b1, 0, 0, 1'b0);
    cmp_n++; if (mv_cnt !== 2) begin err_n++; $display("FAIL basic_count: got %0d exp 2", mv_cnt); end
    cmp_n++; if (cap_period !== 20'd1000) begin err_n++; $display("FAIL basic_period: got %0d exp 1000", cap_period); end
    cmp_n++; if (cap_t_on !== 20'd490) begin err_n++; $display("FAIL basic_t_on: got %0d exp 490", cap_t_on); end
    cmp_n++; if (cap_dead !== 20'd10) begin err_n++; $display("FAIL basic_dead: got %0d exp 10", cap_dead); end
    cmp_n++; if (cap_phase !== 20'd250) begin err_n++; $display("FAIL basic_phase: got %0d exp 250", cap_phase); end
    cmp_n++; if (cap_ok !== 1'b1) begin err_n++; $display("FAIL basic_phase_ok: got %0b exp 1", cap_ok); end
  endtask

  task automatic test_latency;
    run_period(1000, 490, 10, 250, 1'b1, 0, 0, 1'b1);
  endtask

  task automatic test_no_ss;
    repeat (2) run_period(1000, 490, 10, -1, 1'b1, 0, 0, 1'b0);
    cmp_n++; if (cap_phase !== 20'd0) begin err_n++; $display("FAIL noss_phase: got %0d exp 0", cap_phase); end
    cmp_n++; if (cap_ok !== 1'b0) begin err_n++; $display("FAIL noss_phase_ok: got %0b exp 0", cap_ok); end
  endtask

  task automatic test_simultaneous;
    repeat (2) run_period(1000, 490, 10, 0, 1'b1, 0, 0, 1'b0);
    cmp_n++; if (cap_phase !== 20'd0) begin err_n++; $display("FAIL simul_phase: got %0d exp 0", cap_phase); end
    cmp_n++; if (cap_ok !== 1'b1) begin err_n++; $display("FAIL simul_phase_ok: got %0b exp 1", cap_ok); end
    cmp_n++; if (cap_dead !== 20'd10) begin err_n++; $display("FAIL simul_dead: got %0d exp 10", cap_dead); end
  endtask

  task automatic test_no_dead;
    repeat (2) run_period(1000, 490, 10, 250, 1'b0, 0, 0, 1'b0);
    cmp_n++; if (cap_dead !== 20'd0) begin err_n++; $display("FAIL nodead_dead: got %0d exp 0", cap_dead); end
    cmp_n++; if (cap_period !== 20'd1000) begin err_n++; $display("FAIL nodead_period: got %0d exp 1000", cap_period); end
  endtask

  task automatic test_ce;
    run_period(1000, 490, 10, 250, 1'b1, 600, 50, 1'b0);
    run_period(1000, 490, 10, 250, 1'b1, 0, 0, 1'b0);
    cmp_n++; if (cap_period !== 20'd950) begin err_n++; $display("FAIL ce_period: got %0d exp 950", cap_period); end
    cmp_n++; if (cap_t_on !== 20'd490) begin err_n++; $display("FAIL ce_t_on: got %0d exp 490", cap_t_on); end
    cmp_n++; if (cap_dead !== 20'd10) begin err_n++; $display("FAIL ce_dead: got %0d exp 10", cap_dead); end
  endtask

  task automatic test_fault;
    sp = 4'b0000; ss = 4'b0000;
    step(5);
    cmp_n++; if (fault !== 2'b00) begin err_n++; $display("FAIL fault_idle: got %b exp 00", fault); end
    sp[3:2] = 2'b11; step(1); sp[3:2] = 2'b00; step(3);
    cmp_n++; if (fault !== 2'b01) begin err_n++; $display("FAIL fault_set: got %b exp 01", fault); end
    step(5);
    cmp_n++; if (fault !== 2'b01) begin err_n++; $display("FAIL fault_sticky: got %b exp 01", fault); end
    fault_clr = 1'b1; step(1); fault_clr = 1'b0; step(2);
    cmp_n++; if (fault !== 2'b00) begin err_n++; $display("FAIL fault_clear: got %b exp 00", fault); end
    sp[3:2] = 2'b11; step(1); sp[3:2] = 2'b00; step(3);
    ss[1:0] = 2'b11; fault_clr = 1'b1; step(2);
    ss[1:0] = 2'b00; fault_clr = 1'b0; step(2);
    cmp_n++; if (fault !== 2'b10) begin err_n++; $display("FAIL fault_clr_vs_set: got %b exp 10", fault); end
    fault_clr = 1'b1; step(1); fault_clr = 1'b0; step(1);
    cmp_n++; if (fault !== 2'b00) begin err_n++; $display("FAIL fault_clear2: got %b exp 00", fault); end
  endtask

  task automatic test_reset_mid;
    int base;
    repeat (2) run_period(1000, 490, 10, 250, 1'b1, 0, 0, 1'b0);
    sp[0] = 1'b1;
    step(200);
    rst = 1'b0;
    step(1);
    cmp_n++; if ({period, t_on, dead, phase} !== 80'd0) begin err_n++; $display("FAIL rmid_meas: got %0d/%0d/%0d/%0d exp 0", period, t_on, dead, phase); end
    cmp_n++; if ({phase_ok, meas_valid, stall, fault} !== 5'b00000) begin err_n++; $display("FAIL rmid_flags: got %b exp 00000", {phase_ok, meas_valid, stall, fault}); end
    sp = 4'b0000;
    rst = 1'b1;
    step(2);
    base = mv_cnt;
    run_period(1000, 490, 10, 250, 1'b1, 0, 0, 1'b0);
    cmp_n++; if (mv_cnt !== base) begin err_n++; $display("FAIL rmid_rearm: got %0d pulses exp 0", mv_cnt - base); end
    run_period(1000, 490, 10, 250, 1'b1, 0, 0, 1'b0);
    cmp_n++; if (mv_cnt !== base + 1) begin err_n++; $display("FAIL rmid_count: got %0d pulses exp 1", mv_cnt - base); end
    cmp_n++; if (cap_period !== 20'd1000) begin err_n++; $display("FAIL rmid_period: got %0d exp 1000", cap_period); end
  endtask

  task automatic test_stall;
    int base8;
    rst = 1'b0; step(2); rst = 1'b1; step(2);
    base8 = mv8_cnt;
    repeat (3) run_period(100, 45, 5, -1, 1'b1, 0, 0, 1'b0);
    cmp_n++; if (mv8_cnt !== base8 + 2) begin err_n++; $display("FAIL stall_pre_count: got %0d exp 2", mv8_cnt - base8); end
    cmp_n++; if (cap8_period !== 8'd100) begin err_n++; $display("FAIL stall_pre_period: got %0d exp 100", cap8_period); end
    sp = 4'b0000;
    step(140);
    cmp_n++; if (stall8 !== 1'b0) begin err_n++; $display("FAIL stall_early: got %0b exp 0", stall8); end
    step(40);
    cmp_n++; if (stall8 !== 1'b1) begin err_n++; $display("FAIL stall_set: got %0b exp 1", stall8); end
    cmp_n++; if (mv8_cnt !== base8 + 2) begin err_n++; $display("FAIL stall_no_valid: got %0d exp 2", mv8_cnt - base8); end
    cmp_n++; if (period8 !== 8'd100) begin err_n++; $display("FAIL stall_hold: got %0d exp 100", period8); end
    cmp_n++; if (stall !== 1'b0) begin err_n++; $display("FAIL stall_wide: got %0b exp 0", stall); end
    run_period(100, 45, 5, -1, 1'b1, 0, 0, 1'b0);
    cmp_n++; if (stall8 !== 1'b0) begin err_n++; $display("FAIL stall_release: got %0b exp 0", stall8); end
    cmp_n++; if (mv8_cnt !== base8 + 2) begin err_n++; $display("FAIL stall_restart_valid: got %0d exp 2", mv8_cnt - base8); end
    run_period(100, 45, 5, -1, 1'b1, 0, 0, 1'b0);
    cmp_n++; if (mv8_cnt !== base8 + 3) begin err_n++; $display("FAIL stall_resume_count: got %0d exp 3", mv8_cnt - base8); end
    cmp_n++; if (cap8_period !== 8'd100) begin err_n++; $display("FAIL stall_resume_period: got %0d exp 100", cap8_period); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_no_ss();
    test_simultaneous();
    test_no_dead();
    test_ce();
    test_fault();
    test_reset_mid();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
